// File: rtl/e203_exu_fpu_as_arb.sv
// Round-robin arbiter and sequencer for the shared FP add/sub unit.
// One operation in flight; timeout recovers from a hung unit.
module e203_exu_fpu_as_arb #(
    parameter int NREQ    = 2,
    parameter int IDW     = 1,
    parameter int TIMEOUT = 64,
    parameter int CNTW    = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*32-1:0] req_rs1,
    input  logic [NREQ*32-1:0] req_rs2,
    input  logic [NREQ-1:0]   req_sub,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [31:0]       rsp_wdat,
    output logic [1:0]        rsp_ovf,
    output logic              rsp_err,
    output logic              as_i_valid,
    input  logic              as_i_ready,
    output logic [31:0]       as_rs1,
    output logic [31:0]       as_rs2,
    input  logic              as_o_valid,
    output logic              as_o_ready,
    input  logic [31:0]       as_o_wdat,
    input  logic [1:0]        as_o_ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [IDW-1:0]  rr, rr_n;
    logic [CNTW-1:0] timer, timer_n;
    logic [31:0]     rs1_n, rs2_n, wdat_n;
    logic [IDW-1:0]  id_n;
    logic [1:0]      ovf_n;
    logic            err_n;

    logic [31:0]     rs1_a [NREQ];
    logic [31:0]     rs2_a [NREQ];
    logic            found;
    logic [IDW-1:0]  gnt;
    logic [IDW:0]    sum;
    logic [IDW:0]    nxt;

    // The unit raises as_i_ready together with as_o_valid, so it carries no news.
    logic unused_as_i_ready;
    assign unused_as_i_ready = as_i_ready;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign rs1_a[i] = req_rs1[32*i +: 32];
        assign rs2_a[i] = req_rs2[32*i +: 32];
    end

    assign as_i_valid = (state == BUSY);
    assign as_o_ready = (state == BUSY);
    assign rsp_valid  = (state == RESP);

    always_comb begin
        state_n   = state;
        rr_n      = rr;
        timer_n   = timer;
        rs1_n     = as_rs1;
        rs2_n     = as_rs2;
        id_n      = rsp_id;
        wdat_n    = rsp_wdat;
        ovf_n     = rsp_ovf;
        err_n     = rsp_err;
        req_ready = '0;
        found     = 1'b0;
        gnt       = '0;
        sum       = '0;
        nxt       = '0;
        // Cyclic search starting at the round-robin pointer.
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, rr} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ)) begin
                sum = sum - (IDW+1)'(NREQ);
            end
            if (!found && req_valid[sum[IDW-1:0]]) begin
                found = 1'b1;
                gnt   = sum[IDW-1:0];
            end
        end
        unique case (state)
            IDLE: begin
                if (found && !rst) begin
                    req_ready[gnt] = 1'b1;
                    rs1_n   = rs1_a[gnt];
                    rs2_n   = {rs2_a[gnt][31] ^ req_sub[gnt],
                               rs2_a[gnt][30:0]};
                    id_n    = gnt;
                    nxt     = {1'b0, gnt} + (IDW+1)'(1);
                    if (nxt >= (IDW+1)'(NREQ)) begin
                        nxt = '0;
                    end
                    rr_n    = nxt[IDW-1:0];
                    timer_n = '0;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                timer_n = timer + CNTW'(1);
                if (as_o_valid) begin
                    wdat_n  = as_o_wdat;
                    ovf_n   = as_o_ovf;
                    err_n   = 1'b0;
                    state_n = RESP;
                end else if (timer == CNTW'(TIMEOUT-1)) begin
                    wdat_n  = '0;
                    ovf_n   = 2'b00;
                    err_n   = 1'b1;
                    state_n = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr       <= '0;
            timer    <= '0;
            as_rs1   <= '0;
            as_rs2   <= '0;
            rsp_id   <= '0;
            rsp_wdat <= '0;
            rsp_ovf  <= '0;
            rsp_err  <= 1'b0;
        end else begin
            state    <= state_n;
            rr       <= rr_n;
            timer    <= timer_n;
            as_rs1   <= rs1_n;
            as_rs2   <= rs2_n;
            rsp_id   <= id_n;
            rsp_wdat <= wdat_n;
            rsp_ovf  <= ovf_n;
            rsp_err  <= err_n;
        end
    end

endmodule

// File: tb/tb_e203_exu_fpu_as_arb.sv
// Bench for e203_exu_fpu_as_arb: behavioural unit stand-in,
// round-robin reference model and per-scenario checks.
module tb_e203_exu_fpu_as_arb;

    localparam int NREQ = 2;
    localparam int IDW  = 1;
    localparam int TO   = 16;
    localparam int CNTW = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NREQ-1:0]    req_valid, req_ready, req_sub;
    logic [NREQ*32-1:0] req_rs1, req_rs2;
    logic               rsp_valid, rsp_ready, rsp_err;
    logic [IDW-1:0]     rsp_id;
    logic [31:0]        rsp_wdat;
    logic [1:0]         rsp_ovf;
    logic               as_i_valid, as_i_ready, as_o_ready;
    logic [31:0]        as_rs1, as_rs2;
    logic               as_o_valid = 1'b0;
    logic [31:0]        as_o_wdat = '0;
    logic [1:0]         as_o_ovf = '0;

    int checks = 0;
    int failures = 0;

    e203_exu_fpu_as_arb #(
        .NREQ(NREQ), .IDW(IDW), .TIMEOUT(TO), .CNTW(CNTW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_sub(req_sub),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_wdat(rsp_wdat),
        .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
        .as_i_valid(as_i_valid), .as_i_ready(as_i_ready),
        .as_rs1(as_rs1), .as_rs2(as_rs2),
        .as_o_valid(as_o_valid), .as_o_ready(as_o_ready),
        .as_o_wdat(as_o_wdat), .as_o_ovf(as_o_ovf)
    );

    // Stand-in for the add/sub unit: known FP pairs, else integer sum.
    function automatic logic [31:0] unit_fn(input logic [31:0] a,
                                            input logic [31:0] b);
        if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (a == 32'h40400000 && b == 32'hBF800000) return 32'h40000000;
        return a + b;
    endfunction

    function automatic logic [1:0] unit_ovf(input logic [31:0] a,
                                            input logic [31:0] b);
        return a[1:0] ^ b[1:0];
    endfunction

    int   unit_lat = 2;
    logic hang = 1'b0;
    int   ucnt = 0;

    assign as_i_ready = as_o_valid;

    always @(posedge clk) begin
        if (rst || !as_i_valid || as_o_valid) begin
            as_o_valid <= 1'b0;
            ucnt <= 0;
        end else if (!hang) begin
            if (ucnt == unit_lat) begin
                as_o_valid <= 1'b1;
                as_o_wdat  <= unit_fn(as_rs1, as_rs2);
                as_o_ovf   <= unit_ovf(as_rs1, as_rs2);
            end else begin
                ucnt <= ucnt + 1;
            end
        end
    end

    int grants[$];
    int multi = 0;
    int rsp_cnt = 0;

    always @(posedge clk) begin
        if (!rst) begin
            if ($countones(req_ready) > 1) multi <= multi + 1;
            for (int i = 0; i < NREQ; i++)
                if (req_ready[i]) grants.push_back(i);
        end
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
    end

    // Round-robin reference: next pointer and cyclic pick.
    int nxt = 0;

    function automatic int pick(input logic [NREQ-1:0] m, input int p);
        for (int d = 0; d < NREQ; d++)
            if (m[(p + d) % NREQ]) return (p + d) % NREQ;
        return -1;
    endfunction

    task automatic op(input int r, input logic [31:0] a,
                      input logic [31:0] b, input logic s,
                      output logic got, output logic [31:0] w,
                      output logic [1:0] o, output logic e,
                      output logic [IDW-1:0] id,
                      output logic [31:0] rs1_seen,
                      output logic [31:0] rs2_seen,
                      output logic stable, output int lat);
        logic granted;
        granted = 0; got = 0; w = 0; o = 0; e = 0; id = 0;
        rs1_seen = 0; rs2_seen = 0; stable = 0; lat = 0;
        @(negedge clk);
        req_valid[r] = 1'b1;
        req_rs1[32*r +: 32] = a;
        req_rs2[32*r +: 32] = b;
        req_sub[r] = s;
        rsp_ready = 1'b0;
        for (int n = 0; n < 20 && !granted; n++) begin
            #1;
            if (req_ready[r]) granted = 1;
            @(negedge clk);
        end
        req_valid[r] = 1'b0;
        req_rs1[32*r +: 32] = $urandom;
        req_rs2[32*r +: 32] = $urandom;
        req_sub[r] = 1'($urandom);
        if (!granted) return;
        nxt = (r + 1) % NREQ;
        rs1_seen = as_rs1;
        rs2_seen = as_rs2;
        stable = 1;
        for (int n = 0; n < 100 && !rsp_valid; n++) begin
            if (!as_i_valid || as_rs1 !== rs1_seen || as_rs2 !== rs2_seen)
                stable = 0;
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) return;
        got = 1; w = rsp_wdat; o = rsp_ovf; e = rsp_err; id = rsp_id;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    logic g, e, st;
    logic [31:0] w, s1, s2;
    logic [1:0] o;
    logic [IDW-1:0] id;
    int lat;

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '0; req_sub = '0; req_rs1 = '0; req_rs2 = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, as_i_valid, as_o_ready} !== '0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=0",
                     {req_ready, rsp_valid, as_i_valid, as_o_ready});
        end
        checks++;
        if ({rsp_id, rsp_wdat, rsp_ovf, rsp_err, as_rs1, as_rs2} !== '0) begin
            failures++;
            $display("FAIL reset_data wdat=%h rs1=%h rs2=%h want 0",
                     rsp_wdat, as_rs1, as_rs2);
        end
        rst = 1'b0;
        nxt = 0;
    endtask

    task automatic test_add();
        unit_lat = 3; hang = 0;
        op(0, 32'h3F800000, 32'h40000000, 1'b0, g, w, o, e, id, s1, s2, st, lat);
        checks++;
        if (!g || w !== 32'h40400000 || id !== 0 || o !== 0 || e !== 0) begin
            failures++;
            $display("FAIL t1_rsp got=%b w=%h id=%0d o=%b e=%b want w=40400000 id=0",
                     g, w, id, o, e);
        end
        checks++;
        if (!st || s2 !== 32'h40000000 || lat != 5) begin
            failures++;
            $display("FAIL t1_issue stable=%b rs2=%h lat=%0d want 1 40000000 5",
                     st, s2, lat);
        end
    endtask

    task automatic test_sub();
        unit_lat = 1; hang = 0;
        op(1, 32'h40400000, 32'h3F800000, 1'b1, g, w, o, e, id, s1, s2, st, lat);
        checks++;
        if (s2 !== 32'hBF800000) begin
            failures++;
            $display("FAIL t2_rs2 got=%h want=bf800000", s2);
        end
        checks++;
        if (!g || w !== 32'h40000000 || id !== 1 || e !== 0) begin
            failures++;
            $display("FAIL t2_rsp got=%b w=%h id=%0d e=%b want w=40000000 id=1",
                     g, w, id, e);
        end
    endtask

    task automatic test_random();
        int r, L, xl;
        logic [31:0] a, b, xs2, xw;
        logic s, to;
        for (int i = 0; i < 16; i++) begin
            r = $urandom_range(0, NREQ - 1);
            a = $urandom; b = $urandom; s = 1'($urandom);
            L = $urandom_range(0, 6);
            unit_lat = L; hang = 0;
            op(r, a, b, s, g, w, o, e, id, s1, s2, st, lat);
            xs2 = {b[31] ^ s, b[30:0]};
            to = (L + 2 > TO);
            xl = to ? TO : L + 2;
            xw = to ? 32'h0 : unit_fn(a, xs2);
            checks++;
            if (!g || w !== xw || e !== to || id !== IDW'(r) ||
                o !== (to ? 2'b00 : unit_ovf(a, xs2))) begin
                failures++;
                $display("FAIL rand_rsp[%0d] w=%h id=%0d e=%b o=%b want w=%h id=%0d",
                         i, w, id, e, o, xw, r);
            end
            checks++;
            if (s1 !== a || s2 !== xs2 || !st || lat != xl) begin
                failures++;
                $display("FAIL rand_issue[%0d] rs1=%h rs2=%h st=%b lat=%0d want %h %h 1 %0d",
                         i, s1, s2, st, lat, a, xs2, xl);
            end
        end
    endtask

    task automatic test_timeout();
        hang = 1; unit_lat = 0;
        op(0, 32'h12345678, 32'h01020304, 1'b0, g, w, o, e, id, s1, s2, st, lat);
        checks++;
        if (!g || e !== 1 || w !== 0 || o !== 0 || lat != TO) begin
            failures++;
            $display("FAIL t5_hang got=%b e=%b w=%h o=%b lat=%0d want 1 1 0 0 %0d",
                     g, e, w, o, lat, TO);
        end
        hang = 0; unit_lat = TO - 2;
        op(1, 32'h00000100, 32'h00000011, 1'b0, g, w, o, e, id, s1, s2, st, lat);
        checks++;
        if (!g || e !== 0 || w !== 32'h00000111 || lat != TO) begin
            failures++;
            $display("FAIL t5_edge_win e=%b w=%h lat=%0d want 0 00000111 %0d",
                     e, w, lat, TO);
        end
        unit_lat = TO - 1;
        op(0, 32'h00000100, 32'h00000011, 1'b0, g, w, o, e, id, s1, s2, st, lat);
        checks++;
        if (!g || e !== 1 || w !== 0 || lat != TO) begin
            failures++;
            $display("FAIL t5_edge_late e=%b w=%h lat=%0d want 1 0 %0d",
                     e, w, lat, TO);
        end
    endtask

    task automatic test_round_robin();
        int start, m0, x;
        start = grants.size();
        m0 = multi;
        unit_lat = $urandom_range(0, 3); hang = 0;
        rsp_ready = 1'b1;
        @(negedge clk);
        req_rs1 = {$urandom, $urandom}; req_rs2 = {$urandom, $urandom};
        req_valid = 2'b11;
        for (int n = 0; n < 400 && grants.size() < start + 6; n++)
            @(negedge clk);
        req_valid = 2'b00;
        repeat (30) @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (grants.size() != start + 6) begin
            failures++;
            $display("FAIL t3_count got=%0d want=6", grants.size() - start);
        end
        for (int k = 0; k < 6 && start + k < grants.size(); k++) begin
            x = pick(2'b11, nxt);
            nxt = (x + 1) % NREQ;
            checks++;
            if (grants[start + k] != x) begin
                failures++;
                $display("FAIL t3_order[%0d] got=%0d want=%0d",
                         k, grants[start + k], x);
            end
        end
        checks++;
        if (multi != m0) begin
            failures++;
            $display("FAIL t3_onehot got=%0d want=0", multi - m0);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] sw;
        logic [1:0] so;
        logic se, ok, rdy0, hit;
        logic [IDW-1:0] sid;
        int x1, x2;
        unit_lat = 2; hang = 0;
        rsp_ready = 1'b0;
        hit = 0;
        @(negedge clk);
        req_valid = 2'b11;
        for (int n = 0; n < 100 && !hit; n++) begin
            @(negedge clk);
            hit = rsp_valid;
        end
        x1 = pick(2'b11, nxt);
        nxt = (x1 + 1) % NREQ;
        x2 = pick(2'b11, nxt);
        nxt = (x2 + 1) % NREQ;
        checks++;
        if (!hit || rsp_id !== IDW'(x1) || rsp_err !== 0) begin
            failures++;
            $display("FAIL t4_first got=%b id=%0d e=%b want 1 %0d 0",
                     hit, rsp_id, rsp_err, x1);
        end
        sw = rsp_wdat; so = rsp_ovf; se = rsp_err; sid = rsp_id;
        ok = 1; rdy0 = 1;
        repeat (10) begin
            @(negedge clk);
            if (!rsp_valid || rsp_wdat !== sw || rsp_ovf !== so ||
                rsp_err !== se || rsp_id !== sid) ok = 0;
            if (req_ready !== '0) rdy0 = 0;
        end
        checks++;
        if (!ok || !rdy0) begin
            failures++;
            $display("FAIL t4_hold stable=%b ready_low=%b want 1 1", ok, rdy0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 0 || req_ready !== NREQ'(1 << x2)) begin
            failures++;
            $display("FAIL t4_regrant rsp_valid=%b ready=%b want 0 %b",
                     rsp_valid, req_ready, NREQ'(1 << x2));
        end
        @(negedge clk);
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        repeat (20) @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int rc;
        logic gg;
        unit_lat = 10; hang = 0;
        gg = 0;
        @(negedge clk);
        req_rs1[31:0] = 32'hDEADBEEF; req_rs2[31:0] = 32'h0BADF00D;
        req_valid[0] = 1'b1;
        for (int n = 0; n < 20 && !gg; n++) begin
            #1;
            gg = req_ready[0];
            @(negedge clk);
        end
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        nxt = 0;
        rc = rsp_cnt;
        checks++;
        if (!gg || {req_ready, rsp_valid, rsp_err, rsp_wdat, rsp_ovf, rsp_id,
                    as_i_valid, as_o_ready, as_rs1, as_rs2} !== '0) begin
            failures++;
            $display("FAIL t6_clear grant=%b rs1=%h rs2=%h iv=%b want 1 0 0 0",
                     gg, as_rs1, as_rs2, as_i_valid);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (rsp_cnt != rc) begin
            failures++;
            $display("FAIL t6_norsp got=%0d want=0", rsp_cnt - rc);
        end
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            failures++;
            $display("FAIL t6_first_grant got=%b want=01", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
        nxt = 1;
        rsp_ready = 1'b1;
        repeat (20) @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_random();
        test_timeout();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

endmodule
